// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// Purpose:
//   Register file with two combinational read ports and one write port.
//   Entry 0 is hard-wired to zero. A soft clear (or reset) walks a pointer over
//   every entry, zeroing one entry per cycle. While the clear runs, the block
//   reports busy, reads return zero and writes are rejected. A rejected write
//   is flagged by a one-cycle registered pulse on wr_drop.
//
// Parameters:
//   WIDTH   - data width of each entry (default 8)
//   ADDR_W  - address width; DEPTH = 2**ADDR_W entries (default 3)
//
// Ports:
//   clk          in   single clock, rising-edge
//   reset        in   synchronous active-high reset; starts a full clear
//   clear        in   one-cycle request to start a soft clear (ignored if busy)
//   we           in   write enable
//   waddr        in   write address
//   wdata        in   write data
//   raddr_a      in   read address, port A
//   rdata_a      out  read data, port A (combinational)
//   raddr_b      in   read address, port B
//   rdata_b      out  read data, port B (combinational)
//   busy         out  high while a clear sequence is running
//   wr_drop      out  registered pulse: a write was rejected last cycle
//   o_dbg_state  out  current FSM state (0 = IDLE, 1 = CLEAR)
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, a write in progress is forwarded to any
//   read port addressing the same entry in the same cycle. When undefined,
//   reads return the stored value until the cycle after the write edge.
//
// Handshake note:
//   There is no valid/ready pairing on this block. A write is accepted on a
//   rising edge when we=1, busy=0, clear=0 and reset=0; any write attempted
//   while busy=1 or together with clear=1 is refused and reported one cycle
//   later on wr_drop. Writes to entry 0 are silently discarded.
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy,
    output logic              wr_drop,
    output logic [0:0]        o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_drop;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_busy;
    logic              w_wr_ok;
    logic              w_wr_reject;

    assign w_busy = (r_state == S_CLEAR);

    // A write lands only in IDLE, without a competing clear, to a non-zero entry.
    assign w_wr_ok = we && !w_busy && !clear && (waddr != ZERO_ADDR);

    // Refused writes: blocked by a running clear or by a clear issued in the
    // same cycle. Reset overrides everything, so it suppresses the flag too.
    assign w_wr_reject = we && (w_busy || clear);

    // -------------------------------------------------------------------------
    // Control: FSM, clear pointer and the drop flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_ptr     <= ZERO_ADDR;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_reject;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= ZERO_ADDR;
                    end
                end
                S_CLEAR: begin
                    // A clear request here is ignored: the walk just continues.
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ptr   <= ZERO_ADDR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage: no reset on the array itself; the clear walk zeroes it instead.
    // The reset edge writes nothing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_busy) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path, shared by both ports
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!w_busy && (addr != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
            // Forward the write in flight so the reader sees it this cycle.
            if (w_wr_ok && (addr == waddr)) begin
                v = wdata;
            end else begin
                v = r_mem[addr];
            end
`else
            v = r_mem[addr];
`endif
        end
        return v;
    endfunction

    always_comb begin
        rdata_a = f_read(raddr_a);
        rdata_b = f_read(raddr_b);
    end

    assign busy        = w_busy;
    assign wr_drop     = r_wr_drop;
    assign o_dbg_state = r_state;

endmodule
